// File: rtl/tmds_gearbox_serializer.sv
// -----------------------------------------------------------------------------
// tmds_gearbox_serializer
//
// Single-clock gearbox between the TMDS symbol encoders and the DDR output
// primitives. Parallel per-lane symbol words enter a small FIFO through a
// valid/ready handshake. Each symbol is then shifted out BITS_PER_CLK bits per
// clock on every lane, alongside a generated link-clock lane. If the FIFO is
// empty when a new word is due, IDLE_WORD is sent on every lane and the
// underrun status is updated.
//
// Ports:
//   clk_pixel_x5   in   serial-rate clock (only clock)
//   reset_n        in   asynchronous active-low reset
//   enable         in   run request; a drop lets the current word finish
//   clear_status   in   zeroes underrun / underrun_count at the next edge
//   in_valid       in   word bundle valid
//   in_ready       out  FIFO can accept a bundle
//   in_data        in   lane i at [i*WORD_WIDTH +: WORD_WIDTH]
//   out_data       out  lane i at [i*BITS_PER_CLK +: BITS_PER_CLK], bit 0 first
//   out_clock      out  clock-lane chunk, same ordering as out_data
//   load_strobe    out  high while out_data carries the first chunk of a word
//   fifo_level     out  entries currently held in the FIFO
//   underrun       out  sticky: a load found the FIFO empty
//   underrun_count out  saturating count of underrun loads
//   state_dbg      out  FSM state (0 = DISABLED, 1 = RUN)
// -----------------------------------------------------------------------------
module tmds_gearbox_serializer #(
    parameter int                    NUM_CHANNELS  = 3,
    parameter int                    WORD_WIDTH    = 10,
    parameter int                    BITS_PER_CLK  = 2,
    parameter int                    FIFO_DEPTH    = 4,
    parameter bit                    MSB_FIRST     = 1'b0,
    parameter logic [WORD_WIDTH-1:0] CLOCK_PATTERN = 10'b0000011111,
    parameter logic [WORD_WIDTH-1:0] IDLE_WORD     = 10'b1101010100
) (
    input  logic                                   clk_pixel_x5,
    input  logic                                   reset_n,
    input  logic                                   enable,
    input  logic                                   clear_status,
    input  logic                                   in_valid,
    output logic                                   in_ready,
    input  logic [NUM_CHANNELS*WORD_WIDTH-1:0]     in_data,
    output logic [NUM_CHANNELS*BITS_PER_CLK-1:0]   out_data,
    output logic [BITS_PER_CLK-1:0]                out_clock,
    output logic                                   load_strobe,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]        fifo_level,
    output logic                                   underrun,
    output logic [15:0]                            underrun_count,
    output logic                                   state_dbg
);

    localparam int SLOTS  = WORD_WIDTH / BITS_PER_CLK;
    localparam int SLOT_W = (SLOTS > 1) ? $clog2(SLOTS) : 1;
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int LVL_W  = $clog2(FIFO_DEPTH + 1);
    localparam int BUS_W  = NUM_CHANNELS * WORD_WIDTH;

    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SLOTS - 1);
    localparam logic [PTR_W-1:0]  PTR_LAST  = PTR_W'(FIFO_DEPTH - 1);
    localparam logic [LVL_W-1:0]  LVL_FULL  = LVL_W'(FIFO_DEPTH);

    generate
        if (WORD_WIDTH % BITS_PER_CLK != 0) begin : g_bad_width
            $error("WORD_WIDTH must be a multiple of BITS_PER_CLK");
        end
        if (FIFO_DEPTH < 2) begin : g_bad_depth
            $error("FIFO_DEPTH must be at least 2");
        end
    endgenerate

    typedef enum logic {
        S_DISABLED = 1'b0,
        S_RUN      = 1'b1
    } state_t;

    state_t                 state;
    logic [SLOT_W-1:0]      slot;
    logic [WORD_WIDTH-1:0]  lane_sh [NUM_CHANNELS];
    logic [WORD_WIDTH-1:0]  clk_sh;

    logic [BUS_W-1:0]       fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]       wr_ptr;
    logic [PTR_W-1:0]       rd_ptr;
    logic [BUS_W-1:0]       fifo_head;

    logic at_last;
    logic load_go;
    logic stop_go;
    logic fifo_empty;
    logic push;
    logic pop;
    logic underrun_evt;

    // Handshake: a bundle transfers on a rising edge where in_valid && in_ready.
    // in_ready depends only on the registered level, so a pop in the same cycle
    // does not open a slot; the producer sees ready one cycle after the pop.
    assign in_ready   = (fifo_level != LVL_FULL);
    assign push       = in_valid && in_ready;
    assign fifo_empty = (fifo_level == '0);
    assign fifo_head  = fifo_mem[rd_ptr];

    // A load happens on the enable edge out of DISABLED or at the last slot of
    // a word while still enabled; at the last slot with enable low we stop.
    assign at_last      = (state == S_RUN) && (slot == SLOT_LAST);
    assign load_go      = enable && ((state == S_DISABLED) || at_last);
    assign stop_go      = !enable && at_last;
    assign pop          = load_go && !fifo_empty;
    assign underrun_evt = load_go && fifo_empty;

    assign state_dbg = (state == S_RUN);

    // Shift registers always drain toward bit 0; MSB-first words are stored
    // bit-reversed at load so the same low-bit tap serves both orders.
    function automatic logic [WORD_WIDTH-1:0] order_word(input logic [WORD_WIDTH-1:0] w);
        logic [WORD_WIDTH-1:0] r;
        for (int j = 0; j < WORD_WIDTH; j++) begin
            r[j] = w[WORD_WIDTH-1-j];
        end
        return MSB_FIRST ? r : w;
    endfunction

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    // FIFO storage: no reset needed, validity is tracked by the pointers.
    always_ff @(posedge clk_pixel_x5) begin
        if (push) begin
            fifo_mem[wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge clk_pixel_x5 or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else begin
            if (push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            if (push && !pop) begin
                fifo_level <= fifo_level + 1'b1;
            end else if (!push && pop) begin
                fifo_level <= fifo_level - 1'b1;
            end
        end
    end

    // Run/disable FSM with the slot counter and lane shift registers.
    always_ff @(posedge clk_pixel_x5 or negedge reset_n) begin
        if (!reset_n) begin
            state       <= S_DISABLED;
            slot        <= '0;
            load_strobe <= 1'b0;
            clk_sh      <= '0;
            for (int i = 0; i < NUM_CHANNELS; i++) begin
                lane_sh[i] <= '0;
            end
        end else if (load_go) begin
            state       <= S_RUN;
            slot        <= '0;
            load_strobe <= 1'b1;
            clk_sh      <= order_word(CLOCK_PATTERN);
            for (int i = 0; i < NUM_CHANNELS; i++) begin
                lane_sh[i] <= order_word(fifo_empty ? IDLE_WORD
                                                    : fifo_head[i*WORD_WIDTH +: WORD_WIDTH]);
            end
        end else if (stop_go) begin
            state       <= S_DISABLED;
            slot        <= '0;
            load_strobe <= 1'b0;
            clk_sh      <= '0;
            for (int i = 0; i < NUM_CHANNELS; i++) begin
                lane_sh[i] <= '0;
            end
        end else if (state == S_RUN) begin
            slot        <= slot + 1'b1;
            load_strobe <= 1'b0;
            clk_sh      <= clk_sh >> BITS_PER_CLK;
            for (int i = 0; i < NUM_CHANNELS; i++) begin
                lane_sh[i] <= lane_sh[i] >> BITS_PER_CLK;
            end
        end else begin
            load_strobe <= 1'b0;
        end
    end

    // Status: an underrun on the same edge as a clear wins and restarts at 1.
    always_ff @(posedge clk_pixel_x5 or negedge reset_n) begin
        if (!reset_n) begin
            underrun       <= 1'b0;
            underrun_count <= '0;
        end else if (underrun_evt) begin
            underrun <= 1'b1;
            if (clear_status) begin
                underrun_count <= 16'd1;
            end else if (underrun_count != 16'hFFFF) begin
                underrun_count <= underrun_count + 16'd1;
            end
        end else if (clear_status) begin
            underrun       <= 1'b0;
            underrun_count <= '0;
        end
    end

    assign out_clock = clk_sh[BITS_PER_CLK-1:0];

    generate
        for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_out
            assign out_data[g*BITS_PER_CLK +: BITS_PER_CLK] = lane_sh[g][BITS_PER_CLK-1:0];
        end
    endgenerate

endmodule
